// File: rtl/loader_strobe_seq.sv
// loader_strobe_seq: decodes a bank/index address and plays out timed one-hot strobe pulses (optional wrapping burst).
// Latency: the first strobe is high in the cycle after START is accepted. Every output is a register.
// Backpressure: START is taken only while BUSY=0 (IDLE or the DONE cycle). A START seen while busy is dropped, not queued.
//
// Ports:
//   CLK        clock, all state on the rising edge
//   RESET      asynchronous active-low reset
//   START      request; ADDRESS and BURST are sampled when it is accepted
//   ABORT      ends a running sequence (PULSE/GAP) at the next edge
//   ADDRESS    [MSBs] = bank (channel), [LSBs] = starting strobe index
//   BURST      number of additional pulses after the first
//   BUSY       sequence in progress
//   DONE       one-cycle completion pulse
//   ERROR      set with DONE on a faulted request; held until the next accepted START
//   CH_ACTIVE  one-hot selected bank while BUSY
//   STROBE     flattened strobe banks; bank c at [c*STROBE_SIZE +: STROBE_SIZE]
module loader_strobe_seq #(
  parameter int ADDRESS_SIZE = 9,
  parameter int NB_CHANNELS  = 3,
  parameter int CH_BITS      = $clog2(NB_CHANNELS),
  parameter int STROBE_SIZE  = 64,
  parameter int PULSE_CYCLES = 2,
  parameter int GAP_CYCLES   = 1,
  parameter int BURST_SIZE   = 4,
  parameter bit WRAP         = 1'b1
) (
  input  logic                                CLK,
  input  logic                                RESET,
  input  logic                                START,
  input  logic                                ABORT,
  input  logic [ADDRESS_SIZE-1:0]             ADDRESS,
  input  logic [BURST_SIZE-1:0]               BURST,
  output logic                                BUSY,
  output logic                                DONE,
  output logic                                ERROR,
  output logic [NB_CHANNELS-1:0]              CH_ACTIVE,
  output logic [NB_CHANNELS*STROBE_SIZE-1:0]  STROBE
);

  localparam int IDX_BITS = ADDRESS_SIZE - CH_BITS;
  localparam int STROBE_W = NB_CHANNELS * STROBE_SIZE;
  localparam int MAX_CYC  = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
  localparam int CNT_W    = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [CNT_W-1:0]    PULSE_LAST = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0]    GAP_LAST   = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [IDX_BITS-1:0] IDX_LAST   = IDX_BITS'(STROBE_SIZE - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PULSE,
    S_GAP,
    S_DONE
  } state_t;

  state_t                state_q, state_nxt;
  logic [CH_BITS-1:0]    ch_q, ch_nxt;
  logic [IDX_BITS-1:0]   idx_q, idx_nxt;
  logic [BURST_SIZE-1:0] rem_q, rem_nxt;
  logic [CNT_W-1:0]      cnt_q, cnt_nxt;

  logic                  busy_nxt;
  logic                  done_nxt;
  logic                  err_nxt;
  logic [NB_CHANNELS-1:0] ch_active_nxt;
  logic [STROBE_W-1:0]   strobe_nxt;

  logic [CH_BITS-1:0]    addr_ch;
  logic [IDX_BITS-1:0]   addr_idx;
  logic                  req_bad;
  logic                  can_accept;
  logic [31:0]           strobe_pos;

  assign addr_ch    = ADDRESS[ADDRESS_SIZE-1 -: CH_BITS];
  assign addr_idx   = ADDRESS[IDX_BITS-1:0];
  // The channel field can encode banks that do not exist (e.g. 3 with 3 banks),
  // and the index field is wider than one bank.
  assign req_bad    = (32'(addr_ch) >= 32'(NB_CHANNELS)) || (32'(addr_idx) >= 32'(STROBE_SIZE));
  assign can_accept = (state_q == S_IDLE) || (state_q == S_DONE);

  always_comb begin
    state_nxt = state_q;
    ch_nxt    = ch_q;
    idx_nxt   = idx_q;
    rem_nxt   = rem_q;
    cnt_nxt   = cnt_q;
    done_nxt  = 1'b0;
    err_nxt   = ERROR;

    if (can_accept) begin
      if (START) begin
        ch_nxt  = addr_ch;
        idx_nxt = addr_idx;
        rem_nxt = BURST;
        cnt_nxt = '0;
        if (req_bad) begin
          state_nxt = S_DONE;
          done_nxt  = 1'b1;
          err_nxt   = 1'b1;
        end else begin
          state_nxt = S_PULSE;
          err_nxt   = 1'b0;
        end
      end else begin
        state_nxt = S_IDLE;
      end
    end else if (ABORT) begin
      state_nxt = S_DONE;
      done_nxt  = 1'b1;
      err_nxt   = 1'b0;
    end else if (state_q == S_PULSE) begin
      if (cnt_q != PULSE_LAST) begin
        cnt_nxt = cnt_q + CNT_W'(1);
      end else if (rem_q == '0) begin
        state_nxt = S_DONE;
        done_nxt  = 1'b1;
      end else if ((idx_q == IDX_LAST) && !WRAP) begin
        // Running off the end of the bank is a fault when wrapping is disabled.
        state_nxt = S_DONE;
        done_nxt  = 1'b1;
        err_nxt   = 1'b1;
      end else begin
        rem_nxt   = rem_q - BURST_SIZE'(1);
        idx_nxt   = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_BITS'(1);
        cnt_nxt   = '0;
        state_nxt = (GAP_CYCLES > 0) ? S_GAP : S_PULSE;
      end
    end else begin
      // S_GAP
      if (cnt_q != GAP_LAST) begin
        cnt_nxt = cnt_q + CNT_W'(1);
      end else begin
        cnt_nxt   = '0;
        state_nxt = S_PULSE;
      end
    end

    // Output images are computed from the next state so the flops below
    // present them in the same cycle the state register enters that state.
    busy_nxt      = (state_nxt == S_PULSE) || (state_nxt == S_GAP);
    strobe_pos    = 32'(ch_nxt) * 32'(STROBE_SIZE) + 32'(idx_nxt);
    ch_active_nxt = busy_nxt ? (NB_CHANNELS'(1) << ch_nxt) : '0;
    strobe_nxt    = (state_nxt == S_PULSE) ? (STROBE_W'(1) << strobe_pos) : '0;
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q   <= S_IDLE;
      ch_q      <= '0;
      idx_q     <= '0;
      rem_q     <= '0;
      cnt_q     <= '0;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
      ERROR     <= 1'b0;
      CH_ACTIVE <= '0;
      STROBE    <= '0;
    end else begin
      state_q   <= state_nxt;
      ch_q      <= ch_nxt;
      idx_q     <= idx_nxt;
      rem_q     <= rem_nxt;
      cnt_q     <= cnt_nxt;
      BUSY      <= busy_nxt;
      DONE      <= done_nxt;
      ERROR     <= err_nxt;
      CH_ACTIVE <= ch_active_nxt;
      STROBE    <= strobe_nxt;
    end
  end

endmodule

// File: tb/tb_loader_strobe_seq.sv
// tb_loader_strobe_seq: scoreboard bench for loader_strobe_seq (default instance plus a WRAP=0 instance).
// Expected per-cycle output records are queued when a request is accepted and popped on each falling edge.
// Inputs are driven 1 ns after the rising edge; outputs are sampled on the falling edge.
module tb_loader_strobe_seq;

  localparam int PULSE = 2;
  localparam int GAP   = 1;

  logic         CLK = 1'b0;
  logic         RESET = 1'b0;

  logic         START0 = 1'b0, ABORT0 = 1'b0;
  logic [8:0]   ADDRESS0 = '0;
  logic [3:0]   BURST0 = '0;
  logic         BUSY0, DONE0, ERROR0;
  logic [2:0]   CH_ACTIVE0;
  logic [191:0] STROBE0;

  logic         START1 = 1'b0, ABORT1 = 1'b0;
  logic [8:0]   ADDRESS1 = '0;
  logic [3:0]   BURST1 = '0;
  logic         BUSY1, DONE1, ERROR1;
  logic [2:0]   CH_ACTIVE1;
  logic [191:0] STROBE1;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [255:0] q0[$];
  logic [255:0] q1[$];

  loader_strobe_seq dut0 (
    .CLK(CLK), .RESET(RESET), .START(START0), .ABORT(ABORT0),
    .ADDRESS(ADDRESS0), .BURST(BURST0), .BUSY(BUSY0), .DONE(DONE0),
    .ERROR(ERROR0), .CH_ACTIVE(CH_ACTIVE0), .STROBE(STROBE0)
  );

  loader_strobe_seq #(.WRAP(1'b0)) dut1 (
    .CLK(CLK), .RESET(RESET), .START(START1), .ABORT(ABORT1),
    .ADDRESS(ADDRESS1), .BURST(BURST1), .BUSY(BUSY1), .DONE(DONE1),
    .ERROR(ERROR1), .CH_ACTIVE(CH_ACTIVE1), .STROBE(STROBE1)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc++;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] pack(logic b, logic d, logic e, logic [2:0] ca, logic [191:0] s);
    return {58'd0, b, d, e, ca, s};
  endfunction

  // One expected output cycle; ch selects CH_ACTIVE when busy, bi is the
  // single STROBE bit expected high (-1 for none).
  function automatic logic [255:0] rec(bit b, bit d, bit e, int ch, int bi);
    logic [2:0]   ca;
    logic [191:0] s;
    ca = '0;
    s  = '0;
    if (b) ca[ch] = 1'b1;
    if (bi >= 0) s[bi] = 1'b1;
    return pack(b, d, e, ca, s);
  endfunction

  // Builds the expected trace of a request straight from the timing rules:
  // PULSE cycles per pulse, GAP cycles between pulses, then one DONE cycle.
  task automatic push_seq(input int which, input int ch, input int idx, input int burst,
                          input bit wrap, input int abort_at, input int tail);
    logic [255:0] t[$];
    int cur;
    bit err;
    err = 1'b0;
    if (ch >= 3 || idx >= 64) begin
      err = 1'b1;
      t.push_back(rec(0, 1, 1, 0, -1));
    end else begin
      cur = idx;
      for (int p = 0; p <= burst; p++) begin
        for (int c = 0; c < PULSE; c++) t.push_back(rec(1, 0, 0, ch, ch * 64 + cur));
        if (p == burst) break;
        if (cur == 63 && !wrap) begin
          err = 1'b1;
          break;
        end
        cur = (cur + 1) % 64;
        for (int g = 0; g < GAP; g++) t.push_back(rec(1, 0, 0, ch, -1));
      end
      if (abort_at >= 0 && abort_at + 1 < t.size()) begin
        while (t.size() > abort_at + 1) void'(t.pop_back());
        err = 1'b0;
      end
      t.push_back(rec(0, 1, err, 0, -1));
    end
    for (int i = 0; i < tail; i++) t.push_back(rec(0, 0, err, 0, -1));
    foreach (t[i]) begin
      if (which == 0) q0.push_back(t[i]);
      else            q1.push_back(t[i]);
    end
  endtask

  // Called 1 ns after a rising edge. START is held for one edge; the trace is
  // queued at that edge. ADDRESS/BURST are then scrambled to show they are
  // only sampled on accept. abort_at >= 0 raises ABORT in that trace cycle.
  task automatic issue(input int which, input int ch, input int idx, input int burst,
                       input int abort_at, input int tail);
    logic [8:0] a;
    logic [3:0] b;
    a = {ch[1:0], idx[6:0]};
    b = burst[3:0];
    if (which == 0) begin START0 = 1'b1; ADDRESS0 = a; BURST0 = b; end
    else            begin START1 = 1'b1; ADDRESS1 = a; BURST1 = b; end
    @(posedge CLK);
    push_seq(which, ch, idx, burst, (which == 0), abort_at, tail);
    #1;
    START0 = 1'b0; START1 = 1'b0;
    ADDRESS0 = 9'($urandom); BURST0 = 4'($urandom);
    ADDRESS1 = 9'($urandom); BURST1 = 4'($urandom);
    if (abort_at >= 0) begin
      repeat (abort_at) @(posedge CLK);
      #0;
      if (abort_at > 0) #1;
      ABORT0 = 1'b1;
      @(posedge CLK);
      #1;
      ABORT0 = 1'b0;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 200) begin
      @(posedge CLK);
      n++;
    end
    if (q0.size() != 0 || q1.size() != 0) begin
      check("drain_timeout", 256'(q0.size() + q1.size()), '0);
      q0.delete();
      q1.delete();
    end
    #1;
  endtask

  always @(negedge CLK) begin
    if (q0.size() > 0) begin
      logic [255:0] e;
      e = q0.pop_front();
      check($sformatf("dut0_cyc%0d", cyc), pack(BUSY0, DONE0, ERROR0, CH_ACTIVE0, STROBE0), e);
    end
    if (q1.size() > 0) begin
      logic [255:0] e;
      e = q1.pop_front();
      check($sformatf("dut1_cyc%0d", cyc), pack(BUSY1, DONE1, ERROR1, CH_ACTIVE1, STROBE1), e);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (3) @(posedge CLK);
    #1;
    check("reset_dut0", pack(BUSY0, DONE0, ERROR0, CH_ACTIVE0, STROBE0), '0);
    check("reset_dut1", pack(BUSY1, DONE1, ERROR1, CH_ACTIVE1, STROBE1), '0);
    RESET = 1'b1;
    @(posedge CLK);
    #1;

    // 1: single pulse on bank 1 index 5 (bit 69)
    issue(0, 1, 5, 0, -1, 2);
    drain();

    // 2: wrapping burst 190, 191, 128, 129
    issue(0, 2, 62, 3, -1, 1);
    drain();

    // 3: illegal bank, illegal index, then a valid request clears ERROR
    issue(0, 3, 0, 0, -1, 2);
    drain();
    issue(0, 0, 70, 0, -1, 1);
    drain();
    issue(0, 0, 0, 0, -1, 1);
    drain();

    // 4: no-wrap instance runs off the end of bank 0
    issue(1, 0, 63, 2, -1, 2);
    drain();

    // 5a: abort in the first pulse cycle of the wrapping burst
    issue(0, 2, 62, 3, 0, 1);
    drain();

    // 5b: START while busy is ignored
    issue(0, 1, 10, 1, -1, 1);
    @(posedge CLK);
    #1;
    START0 = 1'b1; ADDRESS0 = {2'd0, 7'd3}; BURST0 = 4'd0;
    @(posedge CLK);
    #1;
    START0 = 1'b0;
    drain();

    // 5c: back-to-back, second START presented during the DONE cycle
    issue(0, 0, 1, 0, -1, 0);
    repeat (2) @(posedge CLK);
    #1;
    issue(0, 2, 3, 0, -1, 1);
    drain();

    // 6: asynchronous reset in the middle of the first pulse
    issue(0, 2, 62, 3, -1, 0);
    #1;
    check("pre_reset_busy", 256'(BUSY0), 256'(1));
    check("pre_reset_strobe190", 256'(STROBE0[190]), 256'(1));
    RESET = 1'b0;
    #1;
    q0.delete();
    check("async_reset_dut0", pack(BUSY0, DONE0, ERROR0, CH_ACTIVE0, STROBE0), '0);
    repeat (2) @(posedge CLK);
    #1;
    RESET = 1'b1;
    for (int i = 0; i < 3; i++) q0.push_back(rec(0, 0, 0, 0, -1));
    drain();
    issue(0, 1, 5, 0, -1, 1);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/loader_strobe_seq.md
Name: loader_strobe_seq

Overview:
Parametrised N-channel strobe loader, the next generation of the internal strobe-bank loader. The top address bits select one of NB_CHANNELS strobe banks. The low address bits select the starting strobe index inside that bank. A registered sequencer then emits timed one-hot strobe pulses, optionally as an auto-incrementing burst with wrap control. It adds a start/busy/done handshake, an abort input and error reporting. It sits between the configuration address decoder and the per-bank strobe chains.

Parameters:
ADDRESS_SIZE, 9, total address width.
NB_CHANNELS, 3, number of strobe banks (>=2).
CH_BITS, $clog2(NB_CHANNELS), channel-select width taken from ADDRESS MSBs (derived; do not override).
STROBE_SIZE, 64, strobe bits per bank. Requires 2^(ADDRESS_SIZE-CH_BITS) >= STROBE_SIZE.
PULSE_CYCLES, 2, high time of each strobe pulse in CLK cycles (>=1).
GAP_CYCLES, 1, low time between burst pulses (>=0; 0 = back-to-back).
BURST_SIZE, 4, width of BURST input.
WRAP, 1, 1 = index wraps STROBE_SIZE-1 -> 0 during a burst; 0 = burst stops with error.

Ports:
CLK  input  1  clock, all state on rising edge.
RESET  input  1  asynchronous, active-low reset.
START  input  1  request; accepted when BUSY=0.
ABORT  input  1  terminate current sequence; only effective while BUSY=1.
ADDRESS  input  ADDRESS_SIZE  [ADDRESS_SIZE-1 -: CH_BITS] = channel, [ADDRESS_SIZE-CH_BITS-1:0] = start index; sampled on accept.
BURST  input  BURST_SIZE  number of additional pulses after the first; sampled on accept.
BUSY  output  1  sequence in progress.
DONE  output  1  one-cycle completion pulse.
ERROR  output  1  set with DONE on a faulted request; held until the next accepted START.
CH_ACTIVE  output  NB_CHANNELS  one-hot selected channel while BUSY, else 0.
STROBE  output  NB_CHANNELS*STROBE_SIZE  flattened banks; channel c at [c*STROBE_SIZE +: STROBE_SIZE]; at most one bit high.

Behaviour:
- Reset (RESET=0, asynchronous): state IDLE. All outputs are 0 immediately, including STROBE, BUSY, DONE, ERROR and CH_ACTIVE. Internal counters are 0. Reset mid-burst drops the strobe with no DONE.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- States: IDLE, PULSE, GAP, DONE.
- Accept: START=1 in IDLE or DONE at edge k. At that edge the block latches the channel, the index and a remaining count of BURST, and clears ERROR.
- Validity check at accept:
  - Channel >= NB_CHANNELS or index >= STROBE_SIZE -> DONE at k+1 with DONE=1 and ERROR=1. No strobe and no BUSY.
  - Otherwise -> PULSE.
- PULSE:
  - BUSY=1, CH_ACTIVE=one-hot(channel), STROBE bit (channel*STROBE_SIZE+index)=1 for exactly PULSE_CYCLES cycles. For a valid accept at edge k, the first pulse occupies cycles k+1..k+PULSE_CYCLES.
  - When the pulse ends with remaining=0 -> DONE.
  - When it ends with remaining>0 -> decrement remaining and advance the index. Go to GAP if GAP_CYCLES>0, otherwise straight to the next PULSE.
- Index advance:
  - Index+1.
  - At STROBE_SIZE-1 with WRAP=1 -> index becomes 0.
  - At STROBE_SIZE-1 with WRAP=0 -> DONE with ERROR=1 instead of the next pulse.
- GAP: STROBE all 0, BUSY=1 and CH_ACTIVE held for GAP_CYCLES cycles, then PULSE.
- DONE: exactly one cycle. DONE=1, BUSY=0, STROBE=0, CH_ACTIVE=0.
  - START in this cycle is accepted as if in IDLE; back-to-back requests are allowed.
  - Otherwise -> IDLE.
- ABORT=1 in PULSE or GAP: at the next edge go to DONE. STROBE and CH_ACTIVE clear, DONE=1, ERROR=0. ABORT is ignored in IDLE and DONE. ABORT together with START in IDLE or DONE: the START is accepted.
- START while BUSY=1 is ignored. No queueing.
- ADDRESS and BURST changes after accept have no effect.
- Total valid-sequence duration from accept to DONE = (BURST+1)*PULSE_CYCLES + BURST*GAP_CYCLES + 1 cycles.

Test Plan:
1. Defaults. ADDRESS=9'h085 (ch1, idx5), BURST=0, START at edge k -> STROBE[69]=1 and CH_ACTIVE=3'b010 in cycles k+1..k+2. DONE=1, ERROR=0 at k+3. All other STROBE bits 0 throughout.
2. Wrapping burst. ADDRESS={2'd2,7'd62}, BURST=3, WRAP=1 -> pulses on bits 190, 191, 128, 129, each 2 cycles with a 1-cycle gap between pulses. DONE at k+12.
3. Illegal requests. ADDRESS={2'd3,7'd0} -> DONE=1 and ERROR=1 at k+1, BUSY never 1, STROBE stays 0. Repeat with {2'd0,7'd70} -> same response. ERROR clears on the next valid START.
4. No-wrap instance (WRAP=0). ADDRESS={2'd0,7'd63}, BURST=2 -> single pulse on bit 63 for 2 cycles, then DONE=1 and ERROR=1. No pulse on bit 0.
5. Control. ABORT at cycle k+1 of case 2 -> STROBE=0 and DONE=1, ERROR=0 at the next edge. START while BUSY -> ignored. START during the DONE cycle -> new sequence pulses at DONE+1.
6. RESET low mid-pulse in case 2 -> all outputs 0 asynchronously, before the next CLK edge. No DONE. After RESET=1 a new START operates normally.
